// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared mode constants and sequencer states for the FP ALU shifter
package fp_alu_pkg;

    localparam logic [1:0] MODE_ALIGN = 2'b00;
    localparam logic [1:0] MODE_NORM  = 2'b01;
    localparam logic [1:0] MODE_CARRY = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lzc_window.sv
// rtl/lzc_window.sv - combinational leading-zero count over a Step-bit window
module lzc_window #(
    parameter int Step = 4,
    parameter int CW   = $clog2(Step + 1)
) (
    input  logic [Step-1:0] win_i,
    output logic [CW-1:0]   count_o
);

    logic found;

    // An all-zero window reports Step so the caller shifts a full step.
    always_comb begin
        count_o = CW'(Step);
        found   = 1'b0;
        for (int i = Step - 1; i >= 0; i--) begin
            if (!found && win_i[i]) begin
                count_o = CW'(Step - 1 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_align_normalizer.sv
// rtl/fp_align_normalizer.sv - multi-cycle align / normalise / carry-renormalise mantissa shifter
module fp_align_normalizer
    import fp_alu_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Step          = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     load,
    input  logic [1:0]               mode,
    input  logic [Mantissa_Size:0]   mantissa,
    input  logic                     carry,
    input  logic [Exponent_Size-1:0] exponent,
    input  logic [Exponent_Size-1:0] no_of_shifts,
    output logic [Mantissa_Size:0]   shiftedMantissa,
    output logic [Exponent_Size-1:0] shiftedExponent,
    output logic                     guard,
    output logic                     round,
    output logic                     sticky,
    output logic                     busy,
    output logic                     done,
    output logic                     zero,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int W     = Mantissa_Size + 1;
    localparam int E     = Exponent_Size;
    localparam int EXT_W = Mantissa_Size + 4;
    localparam int RW    = $clog2(EXT_W + 1);
    localparam int CW    = $clog2(Step + 1);

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [W-1:0]   mant_q, mant_d;
    logic [E-1:0]   exp_q, exp_d;
    logic           g_q, g_d, r_q, r_d, s_q, s_d;
    logic           carry_q, carry_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic           zero_q, zero_d, unf_q, unf_d, ovf_q, ovf_d;

    logic [RW-1:0]    ka, n_clamp;
    logic [EXT_W-1:0] ext, sh, lost_mask;
    logic             lost;
    logic [CW-1:0]    lz;
    logic [31:0]      lz32, em1, kn;
    logic [W+1:0]     nw;
    logic [E-1:0]     exp_dec, exp_inc;

    // Align: the bits leaving the s position this step fold into sticky.
    assign ka        = (rem_q > RW'(Step)) ? RW'(Step) : rem_q;
    assign ext       = {mant_q, g_q, r_q, s_q};
    assign sh        = ext >> ka;
    assign lost_mask = (EXT_W'(1) << ka) - EXT_W'(1);
    assign lost      = |(ext & lost_mask);
    assign n_clamp   = (32'(no_of_shifts) > 32'(EXT_W)) ? RW'(EXT_W) : RW'(no_of_shifts);

    lzc_window #(.Step(Step), .CW(CW)) u_lzc (
        .win_i   (mant_q[W-1 -: Step]),
        .count_o (lz)
    );

    // Normalise never takes the exponent below 1.
    assign lz32    = 32'(lz);
    assign em1     = 32'(exp_q) - 32'd1;
    assign kn      = (lz32 < em1) ? lz32 : em1;
    assign nw      = {mant_q, g_q, r_q} << kn;
    assign exp_dec = exp_q - kn[E-1:0];
    assign exp_inc = (&exp_q) ? exp_q : exp_q + E'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        ovf_d   = ovf_q;
        if (load) begin
            state_d = ST_RUN;
            mode_d  = mode;
            mant_d  = mantissa;
            exp_d   = exponent;
            g_d     = 1'b0;
            r_d     = 1'b0;
            s_d     = 1'b0;
            carry_d = carry;
            rem_d   = (mode == MODE_ALIGN) ? n_clamp : '0;
            zero_d  = 1'b0;
            unf_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            case (mode_q)
                MODE_ALIGN: begin
                    {mant_d, g_d, r_d} = sh[EXT_W-1:1];
                    s_d   = sh[0] | lost;
                    rem_d = rem_q - ka;
                    if (rem_q == ka) state_d = ST_DONE;
                end
                MODE_NORM: begin
                    if (exp_q == '0 || mant_q == '0) begin
                        zero_d  = (mant_q == '0);
                        unf_d   = (exp_q == '0);
                        state_d = ST_DONE;
                    end else begin
                        {mant_d, g_d, r_d} = nw;
                        exp_d = exp_dec;
                        if (nw[W+1] || exp_dec == E'(1)) begin
                            unf_d   = !nw[W+1];
                            state_d = ST_DONE;
                        end
                    end
                end
                MODE_CARRY: begin
                    mant_d  = {carry_q, mant_q[W-1:1]};
                    g_d     = mant_q[0];
                    exp_d   = exp_inc;
                    ovf_d   = &exp_inc;
                    state_d = ST_DONE;
                end
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            mant_q  <= '0;
            exp_q   <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign shiftedMantissa = mant_q;
    assign shiftedExponent = exp_q;
    assign guard           = g_q;
    assign round           = r_q;
    assign sticky          = s_q;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign zero            = zero_q;
    assign underflow       = unf_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_fp_align_normalizer.sv
// tb/tb_fp_align_normalizer.sv - randomized bench with behavioural reference for fp_align_normalizer
module tb_fp_align_normalizer;

    localparam int MS   = 23;
    localparam int ES   = 8;
    localparam int STEP = 4;
    localparam int W    = MS + 1;
    localparam int EXTW = MS + 4;

    logic          clk = 1'b0;
    logic          rst, enable, load, carry;
    logic [1:0]    mode;
    logic [W-1:0]  mantissa;
    logic [ES-1:0] exponent, no_of_shifts;
    logic [W-1:0]  shiftedMantissa;
    logic [ES-1:0] shiftedExponent;
    logic          guard, round, sticky, busy, done, zero, underflow, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_align_normalizer #(.Mantissa_Size(MS), .Exponent_Size(ES), .Step(STEP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .mode(mode),
        .mantissa(mantissa), .carry(carry), .exponent(exponent), .no_of_shifts(no_of_shifts),
        .shiftedMantissa(shiftedMantissa), .shiftedExponent(shiftedExponent),
        .guard(guard), .round(round), .sticky(sticky), .busy(busy), .done(done),
        .zero(zero), .underflow(underflow), .overflow(overflow)
    );

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [ES-1:0] exp;
        logic          g, r, s, zero, unf, ovf;
        logic [7:0]    lat;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Whole-operation result from total shift amounts; latency is total/STEP rounded up.
    function automatic res_t model(input logic [1:0] md, input logic [W-1:0] m, input logic c,
                                   input logic [ES-1:0] e, input logic [ES-1:0] n);
        res_t res;
        logic [63:0] ext, sh, lost;
        int nn, clz, tot;
        res = '0;
        res.mant = m;
        res.exp  = e;
        res.lat  = 8'd1;
        case (md)
            2'b00: begin
                nn   = (int'(n) > EXTW) ? EXTW : int'(n);
                ext  = {37'd0, m, 3'b000};
                sh   = ext >> nn;
                lost = ext & ((64'd1 << nn) - 64'd1);
                res.mant = sh[26:3];
                res.g    = sh[2];
                res.r    = sh[1];
                res.s    = sh[0] | (lost != 64'd0);
                res.lat  = (nn == 0) ? 8'd1 : 8'((nn + STEP - 1) / STEP);
            end
            2'b01: begin
                if (m == '0 || e == '0) begin
                    res.zero = (m == '0);
                    res.unf  = (e == '0);
                end else begin
                    clz = 0;
                    while (clz < W && m[W-1-clz] == 1'b0) clz++;
                    tot = (clz < int'(e) - 1) ? clz : int'(e) - 1;
                    res.mant = m << tot;
                    res.exp  = 8'(int'(e) - tot);
                    res.unf  = !res.mant[W-1];
                    res.lat  = (tot == 0) ? 8'd1 : 8'((tot + STEP - 1) / STEP);
                end
            end
            2'b10: begin
                res.mant = {c, m[W-1:1]};
                res.g    = m[0];
                res.exp  = (e == 8'hFF) ? 8'hFF : e + 8'd1;
                res.ovf  = (res.exp == 8'hFF);
            end
            default: ;
        endcase
        return res;
    endfunction

    res_t m_res = '0;
    res_t m_out = '0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic m_ov   = 1'b1;
    int   m_cnt  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_ov   <= 1'b1;
        end else if (enable) begin
            if (load) begin
                m_res  <= model(mode, mantissa, carry, exponent, no_of_shifts);
                m_cnt  <= int'(model(mode, mantissa, carry, exponent, no_of_shifts).lat);
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_out  <= '{mant: mantissa, exp: exponent, default: '0};
                m_ov   <= 1'b1;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= m_res;
                    m_ov   <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                    m_ov  <= 1'b0;
                end
            end
        end
    end

    // Intermediate step values are not architectural; only compare outputs when settled.
    always @(posedge clk) begin
        #2;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (m_ov) begin
            chk("mant", 32'(shiftedMantissa), 32'(m_out.mant));
            chk("exp", 32'(shiftedExponent), 32'(m_out.exp));
            chk("grs", 32'({guard, round, sticky}), 32'({m_out.g, m_out.r, m_out.s}));
            chk("flags", 32'({zero, underflow, overflow}), 32'({m_out.zero, m_out.unf, m_out.ovf}));
        end
    end

    task automatic start(input logic [1:0] md, input logic [W-1:0] m, input logic c,
                         input logic [ES-1:0] e, input logic [ES-1:0] n);
        @(negedge clk);
        enable = 1'b1;
        mode = md; mantissa = m; carry = c; exponent = e; no_of_shifts = n;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    int cyc;
    logic [W-1:0]  rm;
    logic [ES-1:0] re, rn;

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; mode = 2'b00; carry = 1'b0;
        mantissa = '0; exponent = '0; no_of_shifts = '0;
        repeat (3) @(negedge clk);
        chk("rst_mant", 32'(shiftedMantissa), 32'd0);
        chk("rst_busy", 32'({busy, done}), 32'd0);
        rst = 1'b0;

        start(2'b00, 24'h6E2AE6, 1'b0, 8'd6, 8'd5);
        wait_done(cyc);
        chk("align_mant", 32'(shiftedMantissa), 32'h037157);
        chk("align_exp", 32'(shiftedExponent), 32'd6);
        chk("align_grs", 32'({guard, round, sticky}), 32'b001);
        chk("align_lat", 32'(cyc), 32'd2);

        start(2'b01, 24'h062AE6, 1'b0, 8'd6, 8'd0);
        wait_done(cyc);
        chk("norm_mant", 32'(shiftedMantissa), 32'hC55CC0);
        chk("norm_exp", 32'(shiftedExponent), 32'd1);
        chk("norm_unf", 32'(underflow), 32'd0);
        chk("norm_lat", 32'(cyc), 32'd2);

        start(2'b01, 24'h000010, 1'b0, 8'd3, 8'd0);
        wait_done(cyc);
        chk("unf_mant", 32'(shiftedMantissa), 32'h000040);
        chk("unf_exp", 32'(shiftedExponent), 32'd1);
        chk("unf_flag", 32'(underflow), 32'd1);

        start(2'b01, 24'h000000, 1'b0, 8'd5, 8'd0);
        wait_done(cyc);
        chk("zero_flag", 32'(zero), 32'd1);
        chk("zero_exp", 32'(shiftedExponent), 32'd5);

        start(2'b01, 24'h001000, 1'b0, 8'd0, 8'd0);
        wait_done(cyc);
        chk("e0_unf", 32'({underflow, zero}), 32'b10);
        chk("e0_mant", 32'(shiftedMantissa), 32'h001000);

        start(2'b00, 24'h800001, 1'b0, 8'd9, 8'd200);
        wait_done(cyc);
        chk("big_mant", 32'(shiftedMantissa), 32'd0);
        chk("big_grs", 32'({guard, round, sticky}), 32'b001);
        chk("big_lat", 32'(cyc), 32'd7);

        start(2'b10, 24'hFFFFFF, 1'b1, 8'hFE, 8'd0);
        wait_done(cyc);
        chk("cy_mant", 32'(shiftedMantissa), 32'hFFFFFF);
        chk("cy_guard", 32'(guard), 32'd1);
        chk("cy_exp", 32'(shiftedExponent), 32'hFF);
        chk("cy_ovf", 32'(overflow), 32'd1);
        chk("cy_lat", 32'(cyc), 32'd1);

        start(2'b11, 24'h5A5A5A, 1'b1, 8'h33, 8'd9);
        wait_done(cyc);
        chk("rsv_mant", 32'(shiftedMantissa), 32'h5A5A5A);
        chk("rsv_lat", 32'(cyc), 32'd1);

        // Freeze mid-align; a load while frozen must be ignored.
        start(2'b00, 24'hABCDEF, 1'b0, 8'd9, 8'd20);
        @(negedge clk);
        enable = 1'b0;
        load = 1'b1; mode = 2'b11;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        wait_done(cyc);
        chk("frz_lat", 32'(cyc + 4), 32'd8);
        chk("frz_mant", 32'(shiftedMantissa), 32'h00000A);
        chk("frz_grs", 32'({guard, round, sticky}), 32'b101);

        start(2'b00, 24'hFFFFFF, 1'b0, 8'd7, 8'd27);
        repeat (2) @(negedge clk);
        start(2'b01, 24'h062AE6, 1'b0, 8'd6, 8'd0);
        wait_done(cyc);
        chk("rl_mant", 32'(shiftedMantissa), 32'hC55CC0);
        chk("rl_lat", 32'(cyc), 32'd2);

        start(2'b00, 24'h123456, 1'b0, 8'd3, 8'd16);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_out", 32'({shiftedMantissa, shiftedExponent}), 32'd0);
        chk("mrst_st", 32'({busy, done, guard, round, sticky}), 32'd0);
        rst = 1'b0;

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: rm = 24'($urandom);
                1: rm = 24'($urandom >> $urandom_range(8, 31));
                2: rm = 24'h800000 | 24'($urandom >> 12);
                default: rm = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom >> 24);
            endcase
            case ($urandom_range(0, 5))
                0: re = 8'd0;
                1: re = 8'd1;
                2: re = 8'hFE;
                3: re = 8'hFF;
                default: re = 8'($urandom);
            endcase
            rn = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            start(2'($urandom_range(0, 3)), rm, 1'($urandom), re, rn);
            cyc = 0;
            while (done !== 1'b1 && cyc < 300) begin
                enable = ($urandom_range(0, 5) != 0);
                @(negedge clk);
                cyc++;
            end
            enable = 1'b1;
            chk("rnd_done", 32'(done), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_align_normalizer.md
Name: fp_align_normalizer

Overview:
- Multi-cycle parametrised mantissa shifter for the FP ALU datapath.
- Three modes:
  - right-align by a count, tracking guard/round/sticky;
  - left-normalise to a leading 1, decrementing the exponent with underflow clamp;
  - single-step right renormalise after a carry-out, incrementing the exponent with overflow flag.
- Shifts up to Step bits per cycle.
- Sits between the adder/subtractor and the rounding stage.

Parameters:
- Mantissa_Size, 23, stored fraction width; the mantissa bus is Mantissa_Size+1 bits including the hidden bit.
- Exponent_Size, 8, exponent width.
- Step, 4, maximum bit positions shifted per cycle (1..Mantissa_Size+1).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  0 freezes all state; load is also ignored
- load  in  1  capture inputs and start an operation
- mode  in  2  00 align-right, 01 normalise-left, 10 carry renormalise, 11 reserved
- mantissa  in  Mantissa_Size+1  input significand
- carry  in  1  adder carry-out; used by mode 10 only
- exponent  in  Exponent_Size  input exponent
- no_of_shifts  in  Exponent_Size  right-shift count; used by mode 00 only
- shiftedMantissa  out  Mantissa_Size+1  result significand
- shiftedExponent  out  Exponent_Size  result exponent
- guard, round, sticky  out  1 each  bits shifted out below the LSB
- busy  out  1  operation in progress
- done  out  1  result valid; held until the next load or rst
- zero  out  1  mode 01 input mantissa was 0
- underflow  out  1  normalise stopped at exponent 1 without a leading 1, or input exponent was 0
- overflow  out  1  mode 10 result exponent is all-ones

Behaviour:
- Reset: all outputs and internal registers are 0.
- Control priority: rst, then enable=0 (hold), then load, then step.
- Load cycle:
  - Registers the inputs, clears guard/round/sticky and all flags.
  - Sets busy=1 and done=0.
  - Load while busy aborts the current operation and restarts with the new inputs.
- Each following enabled cycle performs one step.
- On the edge where the final step completes: busy goes to 0 and done to 1 together.

Mode 00, align:
- At load, remaining = min(no_of_shifts, Mantissa_Size+4).
- Each step shifts the extended word {mant,g,r,s} right by k = min(Step, remaining), then remaining -= k.
- Zeros enter at the MSB. sticky |= OR of all bits passing below s.
- Exponent is unchanged.
- Latency: ceil(remaining/Step) step cycles. A count of 0 finishes on the first step cycle with the inputs unchanged.

Mode 01, normalise:
- lz = leading zeros within the top Step bits of mant (Step if none).
- k = min(lz, exponent-1).
- Each step shifts {mant,g,r} left by k with zeros entering, and exponent -= k. sticky is unchanged.
- Finishes when:
  - mant MSB=1 (normal result); or
  - exponent reaches 1 (sets underflow); or
  - input exponent=0 (immediate, underflow=1, no shift).
- Mantissa 0 finishes on the first step cycle with zero=1, exponent unchanged.

Mode 10, carry renormalise:
- One step: mant = {carry, mant[M:1]}, guard = old mant[0], exponent += 1.
- overflow=1 if the result exponent is all-ones; the exponent saturates and does not wrap.

Mode 11: finishes on the first step cycle; outputs equal the registered inputs; no flags set.

Decomposition:
- Shared package fp_alu_pkg: mode constants MODE_ALIGN=2'b00, MODE_NORM=2'b01, MODE_CARRY=2'b10, MODE_RSVD=2'b11.
- One sub-module, lzc_window: combinational Step-bit leading-zero counter, output width clog2(Step+1).

Test Plan:
- Align: mode 00, mantissa 0x6E2AE6, exp 6, n=5 -> mantissa 0x037157, exp 6, g=0 r=0 s=1, done after 2 step cycles.
- Normalise: mode 01, mantissa 0x062AE6, exp 6 -> mantissa 0xC55CC0, exp 1, underflow=0, done after 2 step cycles.
- Underflow/zero:
  - mode 01, mantissa 0x000010, exp 3 -> mantissa 0x000040, exp 1, underflow=1;
  - mantissa 0 -> zero=1, exp unchanged.
- Large align: mode 00, mantissa 0x800001, n=200 -> mantissa 0, g=0 r=0 s=1, done after 7 step cycles.
- Carry: mode 10, carry=1, mantissa 0xFFFFFF, exp 0xFE -> mantissa 0xFFFFFF, guard=1, exp 0xFF, overflow=1, done after 1 step cycle.
- Control:
  - enable=0 for 3 cycles mid-align -> state frozen, latency extended by 3;
  - load mid-op -> restart with new inputs;
  - rst mid-op -> all outputs 0 next cycle.
